mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit alongside the single-cycle ALU. It consumes the same SrcA/SrcB register operands and fills the ALU's unimplemented multiply slot.
- Results go to dedicated HI/LO registers, read later by MFHI/MFLO-style datapath muxing.
- Multi-cycle: the control unit stalls the PC while Busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- Start  input  1  request pulse; sampled only in IDLE
- MDControl  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with Start
- SrcA  input  WIDTH  multiplicand / dividend
- SrcB  input  WIDTH  multiplier / divisor
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse; HI/LO valid
- DivZero  output  1  high with Done when a divide had SrcB==0; held until the next accepted Start
- HI  output  WIDTH  product upper half / remainder
- LO  output  WIDTH  product lower half / quotient

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; Busy=0, Done=0, DivZero=0, HI=0, LO=0; all internal registers cleared. Asserting reset mid-operation aborts it, with no HI/LO update.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, Start=1 at edge E0:
  - latch operand magnitudes (absolute values when signed op), sign flags and op; clear counter; DivZero=0; Busy=1.
  - next state MUL or DIV.
  - Exception: divide with SrcB==0 goes directly to FIXUP.
- Start while Busy=1 is ignored; MDControl/SrcA/SrcB changes during Busy are ignored.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; exactly WIDTH cycles (edges E1..EWIDTH), then FIXUP.
- DIV: restoring division, one quotient bit per cycle; exactly WIDTH cycles, then FIXUP.
- FIXUP (edge EWIDTH+1): apply sign correction; write HI/LO; Done=1 for one cycle; Busy=0; next state IDLE.
- Latency: Done high in the cycle after edge WIDTH+1, i.e. WIDTH+2 edges after Start is sampled. HI/LO change only at that edge.
- A new Start is accepted in the same cycle Done is high (back-to-back).
- Signed multiply: product negated (two's complement, 2*WIDTH bits) when operand signs differ.
- Signed divide: quotient truncates toward zero; remainder carries the dividend's sign.
- Signed divide, most-negative / -1: LO=0x80000000, HI=0; no trap.
- Unsigned ops: no fixup; operands are treated as raw magnitudes.
- Divide by zero:
  - E0 → FIXUP, so Done is high after edge E1 (2-cycle latency).
  - LO=all ones; HI=SrcA as latched; DivZero=1.
- Busy=1 from after E0 until the FIXUP edge. Done and Busy are never both high.

Optional Feature:
- Macro: MDU_MTHILO_EN.
- Defined: adds ports HIWrite input 1, LOWrite input 1, WriteData input WIDTH.
  - In IDLE, HIWrite/LOWrite load HI/LO from WriteData at the clock edge; both may be written in the same cycle.
  - If Start and a write occur in the same cycle, the write takes effect and the operation also starts; the operation's result later overwrites HI/LO.
  - Writes while Busy=1 are ignored.
- Undefined: these ports do not exist; HI/LO are written only by FIXUP.

Test Plan:
- MULT signed, SrcA=7, SrcB=-3 (0xFFFFFFFD) -> Done after 34 edges; HI=0xFFFFFFFF, LO=0xFFFFFFEB; DivZero=0.
- MULTU, SrcA=SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV signed, SrcA=-7, SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, SrcA=100, SrcB=7 -> LO=14, HI=2. DIV signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU, SrcA=0x1234, SrcB=0 -> Done after 2 edges; DivZero=1, LO=0xFFFFFFFF, HI=0x1234.
- MULT 5*6 started; second Start (DIVU 9/2) pulsed at cycle 10 -> ignored; HI=0, LO=30 at cycle 34. Then Start during the Done cycle -> accepted back-to-back.
- reset_n low at cycle 15 of a MULT with prior HI/LO=0x11/0x22 -> HI=LO=0, Busy=0 immediately (asynchronous); no Done. With MDU_MTHILO_EN: HIWrite with WriteData=0xABCD in IDLE -> HI=0xABCD; the same write while Busy -> HI unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with dedicated HI/LO result registers.
// MUL is shift-add and DIV is restoring division, each retiring one bit per cycle.
// Signed operations run on magnitudes, and the sign is corrected in FIXUP.
// Optional build macro MDU_MTHILO_EN adds direct HI/LO write ports (HIWrite, LOWrite, WriteData).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [1:0]       MDControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
`ifdef MDU_MTHILO_EN
    input  logic             HIWrite,
    input  logic             LOWrite,
    input  logic [WIDTH-1:0] WriteData,
`endif
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    // state | meaning
    // IDLE  | waiting for Start; HI/LO hold the last result
    // MUL   | shift-add, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // FIXUP | sign correction, HI/LO write, Done pulse
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [1:0]         op;          // [1]=divide, [0]=unsigned
    logic               neg_a, neg_b, dz_pend;
    logic [WIDTH-1:0]   opnd;        // multiplicand for MUL, divisor for DIV
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi, lo;
    logic               done, div_zero;

    logic               in_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

    // Operand conditioning: magnitudes and sign flags at the start request
    always_comb begin
        in_signed = ~MDControl[0];
        a_neg     = in_signed & SrcA[WIDTH-1];
        b_neg     = in_signed & SrcB[WIDTH-1];
        a_mag     = a_neg ? -SrcA : SrcA;
        b_mag     = b_neg ? -SrcB : SrcB;
    end

    // One iteration of multiply and divide, plus the final sign fixup
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod = acc;
        if (~op[0] & (neg_a ^ neg_b))
            prod = -acc;
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (~op[0] & (neg_a ^ neg_b))
            quot = -acc[WIDTH-1:0];
        if (~op[0] & neg_a)
            rem = -acc[2*WIDTH-1:WIDTH];
        // Divide by zero: remainder path carries the dividend back unchanged
        if (dz_pend)
            quot = {WIDTH{1'b1}};
        fix_hi = op[1] ? rem  : prod[2*WIDTH-1:WIDTH];
        fix_lo = op[1] ? quot : prod[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode; iteration ends at the down-counter terminal count
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (!MDControl[1])
                        state_next = MUL;
                    else if (SrcB == '0)
                        state_next = FIXUP;
                    else
                        state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (cnt == '0)
                    state_next = FIXUP;
            end
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            op       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            dz_pend  <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef MDU_MTHILO_EN
                    if (HIWrite)
                        hi <= WriteData;
                    if (LOWrite)
                        lo <= WriteData;
`endif
                    if (Start) begin
                        op       <= MDControl;
                        neg_a    <= a_neg;
                        neg_b    <= b_neg;
                        cnt      <= CNT_LAST;
                        div_zero <= 1'b0;
                        dz_pend  <= MDControl[1] & (SrcB == '0);
                        if (MDControl[1]) begin
                            opnd <= b_mag;
                            if (SrcB == '0)
                                acc <= {a_mag, {WIDTH{1'b0}}};
                            else
                                acc <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CW'(1);
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CW'(1);
                end
                FIXUP: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    done     <= 1'b1;
                    div_zero <= dz_pend;
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state != IDLE);
    assign Done    = done;
    assign DivZero = div_zero;
    assign HI      = hi;
    assign LO      = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          Start;
    logic [1:0]    MDControl;
    logic [W-1:0]  SrcA, SrcB;
    logic          Busy, Done, DivZero;
    logic [W-1:0]  HI, LO;
`ifdef MDU_MTHILO_EN
    logic          HIWrite, LOWrite;
    logic [W-1:0]  WriteData;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .MDControl(MDControl),
        .SrcA(SrcA), .SrcB(SrcB),
`ifdef MDU_MTHILO_EN
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WriteData(WriteData),
`endif
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is E0; returns at the next negedge
    task automatic start_op(input logic [1:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; MDControl = ctl; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Counts edges from E0 (inclusive) until Done is seen at a negedge
    task automatic wait_done(input int already, output int edges);
        int n;
        n = already;
        while (!Done && n < 200) begin
            @(negedge clk);
            n++;
        end
        edges = n + 1;
    endtask

    task automatic do_op(input string tag, input logic [1:0] ctl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, input int eedges);
        int edges;
        start_op(ctl, a, b);
        check({tag, " busy"}, 64'(Busy), 64'(1));
        wait_done(0, edges);
        check({tag, " edges"}, 64'(edges), 64'(eedges));
        check({tag, " HI"}, 64'(HI), 64'(ehi));
        check({tag, " LO"}, 64'(LO), 64'(elo));
        check({tag, " divzero"}, 64'(DivZero), 64'(edz));
        check({tag, " busy_at_done"}, 64'(Busy), 64'(0));
    endtask

    initial begin
        int edges;
        int done_seen;
        reset_n = 1'b0; Start = 1'b0; MDControl = 2'b00; SrcA = '0; SrcB = '0;
`ifdef MDU_MTHILO_EN
        HIWrite = 1'b0; LOWrite = 1'b0; WriteData = '0;
`endif
        #12;
        check("rst busy", 64'(Busy), 64'(0));
        check("rst done", 64'(Done), 64'(0));
        check("rst divzero", 64'(DivZero), 64'(0));
        check("rst HI", 64'(HI), 64'(0));
        check("rst LO", 64'(LO), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_op("mult 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        @(negedge clk);
        do_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        @(negedge clk);
        do_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        @(negedge clk);
        do_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
        @(negedge clk);
        do_op("div minneg/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
        @(negedge clk);
        do_op("divu by 0", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 2);
        @(negedge clk);
        check("divzero held", 64'(DivZero), 64'(1));

        // Second Start during Busy must be ignored, operand changes too
        start_op(2'b00, 32'd5, 32'd6);
        check("divzero cleared", 64'(DivZero), 64'(0));
        repeat (9) @(negedge clk);
        Start = 1'b1; MDControl = 2'b11; SrcA = 32'd9; SrcB = 32'd2;
        @(negedge clk);
        Start = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0;
        wait_done(10, edges);
        check("ignore edges", 64'(edges), 64'(34));
        check("ignore HI", 64'(HI), 64'(0));
        check("ignore LO", 64'(LO), 64'(30));

        // Back-to-back: Start in the Done cycle
        do_op("b2b divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
        @(negedge clk);
        do_op("divu 0x451/0x20", 2'b11, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34);
        @(negedge clk);

        // Asynchronous reset mid-operation
        start_op(2'b00, 32'd3, 32'd4);
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", 64'(Busy), 64'(0));
        check("abort HI", 64'(HI), 64'(0));
        check("abort LO", 64'(LO), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_seen++;
        end
        check("abort no done", 64'(done_seen), 64'(0));

`ifdef MDU_MTHILO_EN
        HIWrite = 1'b1; WriteData = 32'hABCD;
        @(negedge clk);
        HIWrite = 1'b0;
        check("mthi idle", 64'(HI), 64'(32'hABCD));
        LOWrite = 1'b1; WriteData = 32'h1357;
        @(negedge clk);
        LOWrite = 1'b0;
        check("mtlo idle", 64'(LO), 64'(32'h1357));
        start_op(2'b01, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        HIWrite = 1'b1; WriteData = 32'h5555;
        @(negedge clk);
        HIWrite = 1'b0;
        check("mthi busy", 64'(HI), 64'(32'hABCD));
        wait_done(5, edges);
        check("mthi op LO", 64'(LO), 64'(6));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
